// File: rtl/xgmii_loopback_ctrl.sv
// XGMII loopback controller: selects direct, delayed, external or local-fault receive stream,
// switches mode only between frames, and supports single-shot error injection with counters.
module xgmii_loopback_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned LANES     = DATA_WIDTH / 8,
  localparam int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,
  input  logic [DATA_WIDTH-1:0] xgmii_txd,
  input  logic [LANES-1:0]      xgmii_txc,
  input  logic [DATA_WIDTH-1:0] ext_rxd,
  input  logic [LANES-1:0]      ext_rxc,
  input  logic [1:0]            cfg_mode,
  input  logic [DW-1:0]         cfg_delay,
  input  logic                  inj_err,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] xgmii_rxd,
  output logic [LANES-1:0]      xgmii_rxc,
  output logic [1:0]            mode_active,
  output logic                  inj_pending,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_inj_cnt
);

  localparam int unsigned PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned WW = DATA_WIDTH + LANES;

  localparam logic [DATA_WIDTH-1:0] IdleD  = {LANES{8'h07}};
  localparam logic [LANES-1:0]      IdleC  = '1;
  localparam logic [DATA_WIDTH-1:0] FaultD = {(LANES / 4){32'h0100009C}};
  localparam logic [LANES-1:0]      FaultC = {(LANES / 4){4'h1}};

  typedef enum logic [0:0] {StIdle, StFrame} state_e;

  logic [WW-1:0]         dly_q [MAX_DELAY];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_idx;
  logic [1:0]            mode_q, mode_d;
  logic [DW-1:0]         delay_q, delay_d, delay_req;
  state_e                state_q, state_d;
  logic                  pending_q, pending_d, inj_err_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d, sel_d;
  logic [LANES-1:0]      rxc_q, rxc_d, sel_c;
  logic [WW-1:0]         tap;
  logic                  is_start, is_term, fault_mode, in_frame, inject, frame_inc, found;

  // Entry at (wr_ptr - delay) mod MAX_DELAY was written exactly `delay` cycles ago.
  always_comb begin
    if (DW'(wr_ptr_q) >= delay_q) begin
      rd_idx = PW'(DW'(wr_ptr_q) - delay_q);
    end else begin
      rd_idx = PW'(DW'(wr_ptr_q) + DW'(MAX_DELAY) - delay_q);
    end
    tap = dly_q[rd_idx];
    if (delay_q == '0) begin
      tap = {xgmii_txc, xgmii_txd};
    end
  end

  assign wr_ptr_d  = (wr_ptr_q == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign delay_req = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;

  always_comb begin
    sel_d = xgmii_txd;
    sel_c = xgmii_txc;
    unique case (mode_q)
      2'd0: begin
        sel_d = xgmii_txd;
        sel_c = xgmii_txc;
      end
      2'd1: begin
        sel_d = tap[DATA_WIDTH-1:0];
        sel_c = tap[WW-1:DATA_WIDTH];
      end
      2'd2: begin
        sel_d = ext_rxd;
        sel_c = ext_rxc;
      end
      2'd3: begin
        sel_d = FaultD;
        sel_c = FaultC;
      end
    endcase
  end

  always_comb begin
    is_start = sel_c[0] && (sel_d[7:0] == 8'hFB);
    is_term  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_c[i] && (sel_d[8*i +: 8] == 8'hFD)) begin
        is_term = 1'b1;
      end
    end
  end

  assign fault_mode = (mode_q == 2'd3);
  assign in_frame   = !fault_mode && ((state_q == StFrame) || is_start);
  assign inject     = pending_q && in_frame && (sel_c != '1);
  assign frame_inc  = !fault_mode && (state_q == StIdle) && is_start;

  always_comb begin
    rxd_d = sel_d;
    rxc_d = sel_c;
    found = 1'b0;
    if (inject) begin
      for (int i = 0; i < LANES; i++) begin
        if (!found && !sel_c[i]) begin
          rxd_d[8*i +: 8] = 8'hFE;
          rxc_d[i]        = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (fault_mode) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (is_start && !is_term) state_d = StFrame;
        StFrame: if (is_term) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Config only takes effect between frames; a start word also blocks the switch.
    mode_d  = mode_q;
    delay_d = delay_q;
    if ((state_q == StIdle) && !is_start) begin
      mode_d  = cfg_mode;
      delay_d = delay_req;
    end

    pending_d = pending_q;
    if (inject) begin
      pending_d = 1'b0;
    end else if (inj_err && !inj_err_q) begin
      pending_d = 1'b1;
    end

    frame_cnt_d = frame_cnt_q;
    if (cnt_clr) begin
      frame_cnt_d = '0;
    end else if (frame_inc && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (inject && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        dly_q[i] <= {IdleC, IdleD};
      end
      wr_ptr_q <= '0;
    end else begin
      dly_q[wr_ptr_q] <= {xgmii_txc, xgmii_txd};
      wr_ptr_q        <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      rxd_q       <= IdleD;
      rxc_q       <= IdleC;
      mode_q      <= 2'd0;
      delay_q     <= '0;
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      inj_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rxd_q       <= rxd_d;
      rxc_q       <= rxc_d;
      mode_q      <= mode_d;
      delay_q     <= delay_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      inj_err_q   <= inj_err;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign xgmii_rxd   = rxd_q;
  assign xgmii_rxc   = rxc_q;
  assign mode_active = mode_q;
  assign inj_pending = pending_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_inj_cnt = err_cnt_q;

endmodule

// File: tb/tb_xgmii_loopback_ctrl.sv
// Directed bench for xgmii_loopback_ctrl at 64 bits, MAX_DELAY 16, 4-bit counters.
module tb_xgmii_loopback_ctrl;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [63:0] TERM_D  = 64'h07070707070707FD;
  localparam logic [7:0]  TERM_C  = 8'hFF;
  localparam logic [63:0] FAULT_D = 64'h0100009C0100009C;
  localparam logic [63:0] INJ_D   = 64'hD55555555555FEFB;
  localparam logic [63:0] SHORT_D = 64'h070707070707FDFB;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] txd, ext_rxd, rxd;
  logic [7:0]  txc, ext_rxc, rxc;
  logic [1:0]  cfg_mode, mode_active;
  logic [4:0]  cfg_delay;
  logic        inj_err, cnt_clr, inj_pending;
  logic [3:0]  frame_cnt, err_inj_cnt;

  int tests = 0;
  int fails = 0;
  logic [63:0] fq_d[$];
  logic [7:0]  fq_c[$];

  always #5 clk = ~clk;

  xgmii_loopback_ctrl #(
    .DATA_WIDTH(64),
    .MAX_DELAY (16),
    .CNT_WIDTH (4)
  ) dut (
    .clk_156m25  (clk),
    .reset_156m25(rst),
    .xgmii_txd   (txd),
    .xgmii_txc   (txc),
    .ext_rxd     (ext_rxd),
    .ext_rxc     (ext_rxc),
    .cfg_mode    (cfg_mode),
    .cfg_delay   (cfg_delay),
    .inj_err     (inj_err),
    .cnt_clr     (cnt_clr),
    .xgmii_rxd   (rxd),
    .xgmii_rxc   (rxc),
    .mode_active (mode_active),
    .inj_pending (inj_pending),
    .frame_cnt   (frame_cnt),
    .err_inj_cnt (err_inj_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tx(input logic [63:0] d, input logic [7:0] c);
    txd = d;
    txc = c;
    tick();
  endtask

  task automatic build_frame(input int ndata);
    fq_d.delete();
    fq_c.delete();
    fq_d.push_back(START_D);
    fq_c.push_back(START_C);
    for (int i = 0; i < ndata; i++) begin
      fq_d.push_back(64'h0101010101010101 * 64'(i + 1));
      fq_c.push_back(8'h00);
    end
    fq_d.push_back(TERM_D);
    fq_c.push_back(TERM_C);
  endtask

  task automatic test_reset();
    drive_tx(IDLE_D, IDLE_C);
    drive_tx(IDLE_D, IDLE_C);
    rst = 1'b0;
    drive_tx(START_D, START_C);
    drive_tx(64'h1111111111111111, 8'h00);
    rst = 1'b1;
    #1;
    tests++;
    if (rxd !== IDLE_D || rxc !== IDLE_C || frame_cnt !== 4'd0 || mode_active !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: rxd=%h rxc=%h fcnt=%0d mode=%0d, need %h %h 0 0",
               rxd, rxc, frame_cnt, mode_active, IDLE_D, IDLE_C);
    end
    txd = IDLE_D;
    txc = IDLE_C;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (rxd !== IDLE_D || rxc !== IDLE_C || frame_cnt !== 4'd0 || mode_active !== 2'd0 ||
        inj_pending !== 1'b0 || err_inj_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_release: rxd=%h rxc=%h fcnt=%0d mode=%0d pend=%b ecnt=%0d",
               rxd, rxc, frame_cnt, mode_active, inj_pending, err_inj_cnt);
    end
  endtask

  task automatic test_direct();
    build_frame(6);
    for (int i = 0; i < fq_d.size(); i++) begin
      drive_tx(fq_d[i], fq_c[i]);
      tests++;
      if (rxd !== fq_d[i] || rxc !== fq_c[i]) begin
        fails++;
        $display("FAIL direct_word%0d: got %h/%h need %h/%h", i, rxd, rxc, fq_d[i], fq_c[i]);
      end
    end
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (frame_cnt !== 4'd1) begin
      fails++;
      $display("FAIL direct_fcnt: got %0d need 1", frame_cnt);
    end
  endtask

  task automatic test_mode_change();
    build_frame(6);
    for (int i = 0; i < fq_d.size(); i++) begin
      if (i == 3) begin
        cfg_mode  = 2'd1;
        cfg_delay = 5'd5;
      end
      drive_tx(fq_d[i], fq_c[i]);
      tests++;
      if (rxd !== fq_d[i] || rxc !== fq_c[i] || mode_active !== 2'd0) begin
        fails++;
        $display("FAIL mc_hold%0d: got %h/%h mode=%0d need %h/%h mode=0",
                 i, rxd, rxc, mode_active, fq_d[i], fq_c[i]);
      end
    end
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (mode_active !== 2'd1) begin
      fails++;
      $display("FAIL mc_apply: mode got %0d need 1", mode_active);
    end
    repeat (6) drive_tx(IDLE_D, IDLE_C);
    build_frame(4);
    repeat (6) begin
      fq_d.push_back(IDLE_D);
      fq_c.push_back(IDLE_C);
    end
    for (int c = 0; c < fq_d.size(); c++) begin
      drive_tx(fq_d[c], fq_c[c]);
      if (c >= 5) begin
        tests++;
        if (rxd !== fq_d[c-5] || rxc !== fq_c[c-5]) begin
          fails++;
          $display("FAIL delay5_word%0d: got %h/%h need %h/%h",
                   c - 5, rxd, rxc, fq_d[c-5], fq_c[c-5]);
        end
      end
    end
    tests++;
    if (frame_cnt !== 4'd3) begin
      fails++;
      $display("FAIL mc_fcnt: got %0d need 3", frame_cnt);
    end
    cfg_mode  = 2'd0;
    cfg_delay = 5'd0;
    drive_tx(IDLE_D, IDLE_C);
    drive_tx(IDLE_D, IDLE_C);
  endtask

  task automatic test_inject();
    inj_err = 1'b1;
    drive_tx(IDLE_D, IDLE_C);
    inj_err = 1'b0;
    drive_tx(IDLE_D, IDLE_C);
    inj_err = 1'b1;
    drive_tx(IDLE_D, IDLE_C);
    inj_err = 1'b0;
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (inj_pending !== 1'b1 || err_inj_cnt !== 4'd0) begin
      fails++;
      $display("FAIL inj_armed: pend=%b ecnt=%0d need 1 0", inj_pending, err_inj_cnt);
    end
    build_frame(6);
    for (int i = 0; i < fq_d.size(); i++) begin
      drive_tx(fq_d[i], fq_c[i]);
      tests++;
      if (i == 0) begin
        if (rxd !== INJ_D || rxc !== 8'h03 || err_inj_cnt !== 4'd1 || inj_pending !== 1'b0) begin
          fails++;
          $display("FAIL inj_start: got %h/%h ecnt=%0d pend=%b need %h/03 1 0",
                   rxd, rxc, err_inj_cnt, inj_pending, INJ_D);
        end
      end else if (rxd !== fq_d[i] || rxc !== fq_c[i]) begin
        fails++;
        $display("FAIL inj_word%0d: got %h/%h need %h/%h", i, rxd, rxc, fq_d[i], fq_c[i]);
      end
    end
    build_frame(3);
    for (int i = 0; i < fq_d.size(); i++) begin
      drive_tx(fq_d[i], fq_c[i]);
      tests++;
      if (rxd !== fq_d[i] || rxc !== fq_c[i]) begin
        fails++;
        $display("FAIL inj_clean%0d: got %h/%h need %h/%h", i, rxd, rxc, fq_d[i], fq_c[i]);
      end
    end
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (err_inj_cnt !== 4'd1 || frame_cnt !== 4'd5) begin
      fails++;
      $display("FAIL inj_counts: ecnt=%0d fcnt=%0d need 1 5", err_inj_cnt, frame_cnt);
    end
  endtask

  task automatic test_fault_ext();
    cfg_mode = 2'd3;
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (mode_active !== 2'd3) begin
      fails++;
      $display("FAIL fault_apply: mode got %0d need 3", mode_active);
    end
    drive_tx(IDLE_D, IDLE_C);
    build_frame(3);
    for (int i = 0; i < fq_d.size(); i++) begin
      inj_err = (i == 1);
      drive_tx(fq_d[i], fq_c[i]);
      tests++;
      if (rxd !== FAULT_D || rxc !== 8'h11) begin
        fails++;
        $display("FAIL fault_word%0d: got %h/%h need %h/11", i, rxd, rxc, FAULT_D);
      end
    end
    inj_err = 1'b0;
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (frame_cnt !== 4'd5 || inj_pending !== 1'b1 || err_inj_cnt !== 4'd1) begin
      fails++;
      $display("FAIL fault_hold: fcnt=%0d pend=%b ecnt=%0d need 5 1 1",
               frame_cnt, inj_pending, err_inj_cnt);
    end
    ext_rxd  = IDLE_D;
    ext_rxc  = IDLE_C;
    cfg_mode = 2'd2;
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (mode_active !== 2'd2) begin
      fails++;
      $display("FAIL ext_apply: mode got %0d need 2", mode_active);
    end
    ext_rxd = 64'h0123456789ABCDEF;
    ext_rxc = 8'h00;
    tick();
    tests++;
    if (rxd !== 64'h0123456789ABCDEF || rxc !== 8'h00 || inj_pending !== 1'b1) begin
      fails++;
      $display("FAIL ext_pass: got %h/%h pend=%b need 0123456789abcdef/00 1", rxd, rxc, inj_pending);
    end
    ext_rxd = START_D;
    ext_rxc = START_C;
    tick();
    tests++;
    if (rxd !== INJ_D || rxc !== 8'h03 || err_inj_cnt !== 4'd2 || inj_pending !== 1'b0) begin
      fails++;
      $display("FAIL ext_inj: got %h/%h ecnt=%0d pend=%b need %h/03 2 0",
               rxd, rxc, err_inj_cnt, inj_pending, INJ_D);
    end
    ext_rxd = TERM_D;
    ext_rxc = TERM_C;
    tick();
    tests++;
    if (rxd !== TERM_D || rxc !== TERM_C || frame_cnt !== 4'd6) begin
      fails++;
      $display("FAIL ext_term: got %h/%h fcnt=%0d need %h/%h 6", rxd, rxc, frame_cnt, TERM_D, TERM_C);
    end
    ext_rxd = IDLE_D;
    ext_rxc = IDLE_C;
    tick();
  endtask

  task automatic test_delay_clamp();
    logic found;
    int   lat;
    cfg_mode  = 2'd1;
    cfg_delay = 5'd31;
    drive_tx(IDLE_D, IDLE_C);
    tests++;
    if (mode_active !== 2'd1) begin
      fails++;
      $display("FAIL clamp_apply: mode got %0d need 1", mode_active);
    end
    repeat (20) drive_tx(IDLE_D, IDLE_C);
    txd   = 64'hA5A5A5A5A5A5A5A5;
    txc   = 8'h00;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      txd = IDLE_D;
      txc = IDLE_C;
      if (rxd === 64'hA5A5A5A5A5A5A5A5 && rxc === 8'h00) begin
        found = 1'b1;
        lat   = k;
      end
    end
    tests++;
    if (!found || lat != 17) begin
      fails++;
      $display("FAIL clamp_latency: found=%b latency=%0d need 1 17", found, lat);
    end
    cfg_mode  = 2'd0;
    cfg_delay = 5'd0;
    drive_tx(IDLE_D, IDLE_C);
    drive_tx(IDLE_D, IDLE_C);
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1;
    drive_tx(IDLE_D, IDLE_C);
    cnt_clr = 1'b0;
    tests++;
    if (frame_cnt !== 4'd0 || err_inj_cnt !== 4'd0 || mode_active !== 2'd0) begin
      fails++;
      $display("FAIL sat_clear: fcnt=%0d ecnt=%0d mode=%0d need 0 0 0",
               frame_cnt, err_inj_cnt, mode_active);
    end
    repeat (15) drive_tx(SHORT_D, 8'hFF);
    tests++;
    if (frame_cnt !== 4'd15 || rxd !== SHORT_D) begin
      fails++;
      $display("FAIL sat_15: fcnt=%0d rxd=%h need 15 %h", frame_cnt, rxd, SHORT_D);
    end
    drive_tx(SHORT_D, 8'hFF);
    tests++;
    if (frame_cnt !== 4'd15) begin
      fails++;
      $display("FAIL sat_hold: fcnt=%0d need 15", frame_cnt);
    end
    cnt_clr = 1'b1;
    drive_tx(SHORT_D, 8'hFF);
    cnt_clr = 1'b0;
    tests++;
    if (frame_cnt !== 4'd0) begin
      fails++;
      $display("FAIL sat_clr_wins: fcnt=%0d need 0", frame_cnt);
    end
    drive_tx(SHORT_D, 8'hFF);
    tests++;
    if (frame_cnt !== 4'd1) begin
      fails++;
      $display("FAIL sat_resume: fcnt=%0d need 1", frame_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    txd       = IDLE_D;
    txc       = IDLE_C;
    ext_rxd   = IDLE_D;
    ext_rxc   = IDLE_C;
    cfg_mode  = 2'd0;
    cfg_delay = 5'd0;
    inj_err   = 1'b0;
    cnt_clr   = 1'b0;
    test_reset();
    test_direct();
    test_mode_change();
    test_inject();
    test_fault_ext();
    test_delay_clamp();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
